bt_ascii_bcd_frame: RTL and testbench

Upstream stage of the Bluetooth frequency-control path. It consumes bytes from the UART receiver and assembles a line of ASCII decimal digits into a right-aligned 8-digit packed BCD word. On a clean line terminator it presents the word with a one-cycle valid strobe. Its output feeds the BCD-to-binary converter (low 28 bits used), which in turn drives the DDS frequency word.

---
 rtl/bt_pkg.sv | 47 ++++
 rtl/bt_idle_timer.sv | 46 ++++
 rtl/bt_ascii_bcd_frame.sv | 152 +++++++++++++++
 tb/tb_bt_ascii_bcd_frame.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// =============================================================================
// Module : bt_pkg
// Shared constants, state encodings and the byte classifier for the Bluetooth
// frequency-control path.
// Rev    : 1.0
// =============================================================================
`default_nettype none

package bt_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  localparam int DEFAULT_MAX_DIGITS  = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_DIGIT = 2'd0,
    CLS_TERM  = 2'd1,
    CLS_SPACE = 2'd2,
    CLS_OTHER = 2'd3
  } byte_cls_e;

  function automatic byte_cls_e classify(input logic [7:0] b);
    if (b >= ASCII_0 && b <= ASCII_9) begin
      return CLS_DIGIT;
    end else if (b == ASCII_CR || b == ASCII_LF) begin
      return CLS_TERM;
    end else if (b == ASCII_SP) begin
      return CLS_SPACE;
    end else begin
      return CLS_OTHER;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/bt_idle_timer.sv
// =============================================================================
// Module : bt_idle_timer
// Counts idle cycles while enabled; strobes expire on the TIMEOUT_CYC-th one.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module bt_idle_timer
  import bt_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A clear in the expiry cycle suppresses the strobe: the byte wins.
  assign expire_o = enable_i && !clear_i && (count_q == LAST);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear_i || !enable_i || expire_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bt_ascii_bcd_frame.sv
// =============================================================================
// Module : bt_ascii_bcd_frame
// Assembles a terminated line of ASCII digits into a right-aligned packed BCD word.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module bt_ascii_bcd_frame
  import bt_pkg::*;
#(
  parameter int MAX_DIGITS  = DEFAULT_MAX_DIGITS,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [4*MAX_DIGITS-1:0] bcd_data,
  output logic                    bcd_valid,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int SR_W  = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   bcd_data_q, bcd_data_d;
  logic              bcd_valid_q, bcd_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;

  byte_cls_e         cls;
  logic [3:0]        nibble;
  logic              expire;

  assign cls    = classify(rx_data);
  // Digits are 0x30..0x39, so the low nibble already equals byte - 0x30.
  assign nibble = rx_data[3:0];

  bt_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (rx_valid || (state_q == ST_IDLE)),
    .enable_i (state_q != ST_IDLE),
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    bcd_data_d  = bcd_data_q;
    bcd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (cls)
            CLS_DIGIT: begin
              sr_d    = {{(SR_W-4){1'b0}}, nibble};
              cnt_d   = CNT_W'(1);
              state_d = ST_RECV;
            end
            CLS_OTHER: frame_err_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_RECV: begin
        if (rx_valid) begin
          case (cls)
            CLS_DIGIT: begin
              if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                sr_d  = {sr_q[SR_W-5:0], nibble};
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                state_d = ST_DISCARD;
              end
            end
            CLS_TERM: begin
              bcd_data_d  = sr_q;
              bcd_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = ST_IDLE;
            end
            default: state_d = ST_DISCARD;
          endcase
        end else if (expire) begin
          frame_err_d = 1'b1;
          sr_d        = '0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        if (rx_valid) begin
          if (cls == CLS_TERM) begin
            frame_err_d = 1'b1;
            sr_d        = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end
        end else if (expire) begin
          frame_err_d = 1'b1;
          sr_d        = '0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      bcd_data_q  <= '0;
      bcd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      bcd_data_q  <= bcd_data_d;
      bcd_valid_q <= bcd_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bcd_data  = bcd_data_q;
  assign bcd_valid = bcd_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bt_ascii_bcd_frame.sv
// =============================================================================
// Module : tb_bt_ascii_bcd_frame
// Cycle-by-cycle vector table plus hand sequences for timeout and reset.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_bt_ascii_bcd_frame;

  localparam int MAX_DIGITS  = 8;
  localparam int TIMEOUT_CYC = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] bcd_data;
  logic        bcd_valid;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        bv;
    logic        fe;
    logic        busy;
    logic [31:0] bcd;
  } vec_t;

  vec_t vecs[$];

  bt_ascii_bcd_frame #(
    .MAX_DIGITS  (MAX_DIGITS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .bcd_data  (bcd_data),
    .bcd_valid (bcd_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic [7:0] d, input logic v, input logic bv,
                     input logic fe, input logic bz, input logic [31:0] bcd);
    vec_t t;
    t.data = d; t.valid = v; t.bv = bv; t.fe = fe; t.busy = bz; t.bcd = bcd;
    vecs.push_back(t);
  endtask

  // Packed as {bcd_valid, frame_err, busy, bcd_data}.
  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got bv=%b fe=%b busy=%b bcd=%h, need bv=%b fe=%b busy=%b bcd=%h",
               name, act[34], act[33], act[32], act[31:0], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  function automatic logic [34:0] outs();
    return {bcd_valid, frame_err, busy, bcd_data};
  endfunction

  // Drive for one cycle, then sample just after the edge that consumed it.
  task automatic step(input logic [7:0] d, input logic v);
    @(negedge clk);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0);
  endtask

  initial begin
    logic early_bad;

    // Normal frame, then bytes immediately back to back.
    add("7", 1, 0, 0, 1, 32'h0);
    add("8", 1, 0, 0, 1, 32'h0);
    add("0", 1, 0, 0, 1, 32'h0);
    add("0", 1, 0, 0, 1, 32'h0);
    add("0", 1, 0, 0, 1, 32'h0);
    add("0", 1, 0, 0, 1, 32'h0);
    add(8'h0A, 1, 1, 0, 0, 32'h00780000);
    add(8'h00, 0, 0, 0, 0, 32'h00780000);
    // Leading space, CR LF pair.
    add(8'h20, 1, 0, 0, 0, 32'h00780000);
    add("1", 1, 0, 0, 1, 32'h00780000);
    add("2", 1, 0, 0, 1, 32'h00780000);
    add("5", 1, 0, 0, 1, 32'h00780000);
    add(8'h0D, 1, 1, 0, 0, 32'h00000125);
    add(8'h0A, 1, 0, 0, 0, 32'h00000125);
    // Nine digits overflows.
    for (int i = 1; i <= 9; i++) add(8'h30 + 8'(i), 1, 0, 0, 1, 32'h00000125);
    add(8'h0A, 1, 0, 1, 0, 32'h00000125);
    add(8'h00, 0, 0, 0, 0, 32'h00000125);
    // Bad character mid-frame, then a fresh frame right after the TERM.
    add("4", 1, 0, 0, 1, 32'h00000125);
    add("A", 1, 0, 0, 1, 32'h00000125);
    add("2", 1, 0, 0, 1, 32'h00000125);
    add(8'h0A, 1, 0, 1, 0, 32'h00000125);
    add("9", 1, 0, 0, 1, 32'h00000125);
    add(8'h0A, 1, 1, 0, 0, 32'h00000009);
    // OTHER while idle, and junk data with no valid.
    add("X", 1, 0, 1, 0, 32'h00000009);
    add("X", 0, 0, 0, 0, 32'h00000009);
    // Exactly eight digits is accepted.
    for (int i = 1; i <= 8; i++) add(8'h30 + 8'(i), 1, 0, 0, 1, 32'h00000009);
    add(8'h0D, 1, 1, 0, 0, 32'h12345678);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", outs(), 35'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", outs(), 35'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].data, vecs[i].valid);
      check($sformatf("vec%0d", i), outs(), {vecs[i].bv, vecs[i].fe, vecs[i].busy, vecs[i].bcd});
    end

    // Timeout: '5' then 100 idle cycles.
    step("5", 1'b1);
    early_bad = 1'b0;
    for (int i = 1; i < TIMEOUT_CYC; i++) begin
      step(8'h00, 1'b0);
      if (frame_err !== 1'b0 || busy !== 1'b1) early_bad = 1'b1;
    end
    checks++;
    if (early_bad) begin
      errors++;
      $display("FAIL timeout_early: got early frame_err or busy drop, need none before cycle %0d", TIMEOUT_CYC);
    end
    step(8'h00, 1'b0);
    check("timeout_expire", outs(), {1'b0, 1'b1, 1'b0, 32'h12345678});
    step(8'h00, 1'b0);
    check("timeout_after", outs(), {1'b0, 1'b0, 1'b0, 32'h12345678});

    // Byte on the expiry cycle continues the frame.
    step("5", 1'b1);
    idle(TIMEOUT_CYC - 1);
    step("6", 1'b1);
    check("timeout_byte_wins", outs(), {1'b0, 1'b0, 1'b1, 32'h12345678});
    step(8'h0A, 1'b1);
    check("timeout_byte_frame", outs(), {1'b1, 1'b0, 1'b0, 32'h00000056});

    // Reset mid-frame aborts with no strobes.
    step("3", 1'b1);
    step("3", 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_async", outs(), 35'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_mid_hold", outs(), 35'h0);
    @(negedge clk);
    rst = 1'b0;
    step("6", 1'b1);
    check("rst_new_digit", outs(), {1'b0, 1'b0, 1'b1, 32'h0});
    step(8'h0A, 1'b1);
    check("rst_new_frame", outs(), {1'b1, 1'b0, 1'b0, 32'h00000006});
    step(8'h00, 1'b0);
    check("rst_new_after", outs(), {1'b0, 1'b0, 1'b0, 32'h00000006});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
